// File: rtl/oai21_pipe_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oai21_pipe_bank                                                            |
// | WIDTH-wide OAI21/AOI21 gate bank, DEPTH-stage pipeline with valid,         |
// | global hold and a full-scan shift chain through the data registers.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module oai21_pipe_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             EN,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] B2,
    input  logic             HOLD,
    input  logic             SE,
    input  logic             SI,
    output logic [WIDTH-1:0] ZN,
    output logic             VLD,
    output logic             SO
);

    localparam int c_CHAIN_BITS = WIDTH * DEPTH;

    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            r_vld;
    logic [DEPTH-1:0][WIDTH-1:0] w_data_norm;
    logic [DEPTH-1:0]            w_vld_norm;
    logic [DEPTH-1:0][WIDTH-1:0] w_data_scan;
    logic [c_CHAIN_BITS-1:0]     w_flat;
    logic [WIDTH-1:0]            w_func;

    assign w_func = MODE ? ~(A | (B1 & B2)) : ~(A & (B1 | B2));

    // Packed layout makes bit s*WIDTH+k the chain position of D[s][k],
    // so a single left shift walks SI through every stage in order.
    assign w_flat      = r_data;
    assign w_data_scan = (w_flat << 1) | c_CHAIN_BITS'(SI);

    always_comb begin
        w_data_norm    = r_data;
        w_vld_norm     = r_vld;
        w_data_norm[0] = EN ? w_func : r_data[0];
        w_vld_norm[0]  = EN;
        for (int s = 1; s < DEPTH; s++) begin
            w_data_norm[s] = r_data[s-1];
            w_vld_norm[s]  = r_vld[s-1];
        end
    end

    // Scan shifts data only; valid bits keep their state across a scan burst.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_data <= '0;
            r_vld  <= '0;
        end else if (SE) begin
            r_data <= w_data_scan;
        end else if (!HOLD) begin
            r_data <= w_data_norm;
            r_vld  <= w_vld_norm;
        end
    end

    assign ZN  = r_data[DEPTH-1];
    assign VLD = r_vld[DEPTH-1];
    assign SO  = r_data[DEPTH-1][WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_oai21_pipe_bank.sv
`default_nettype none
// Directed plus randomized checks of oai21_pipe_bank (WIDTH=4, DEPTH=2)
// against a flat-integer model of the pipeline and scan chain.
module tb_oai21_pipe_bank;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int NBITS = WIDTH * DEPTH;

    logic             CK = 1'b0;
    logic             RN, EN, MODE, HOLD, SE, SI;
    logic [WIDTH-1:0] A, B1, B2;
    logic [WIDTH-1:0] ZN;
    logic             VLD, SO;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: whole data state as one integer (stage 0 in the low bits),
    // valid bits as another integer.
    longint unsigned m_flat = 0;
    int unsigned     m_v    = 0;

    oai21_pipe_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CK(CK), .RN(RN), .EN(EN), .MODE(MODE), .A(A), .B1(B1), .B2(B2),
        .HOLD(HOLD), .SE(SE), .SI(SI), .ZN(ZN), .VLD(VLD), .SO(SO)
    );

    always #5 CK = ~CK;

    function automatic longint unsigned gate_fn(logic md, logic [WIDTH-1:0] a,
                                                logic [WIDTH-1:0] b1, logic [WIDTH-1:0] b2);
        logic [WIDTH-1:0] r;
        r = md ? ~(a | (b1 & b2)) : ~(a & (b1 | b2));
        return longint'(r);
    endfunction

    task automatic model_edge();
        longint unsigned mask, wmask, s0;
        mask  = (64'd1 << NBITS) - 1;
        wmask = (64'd1 << WIDTH) - 1;
        if (!RN) return;
        if (SE) begin
            m_flat = ((m_flat << 1) | longint'(SI)) & mask;
        end else if (!HOLD) begin
            s0     = EN ? gate_fn(MODE, A, B1, B2) : (m_flat & wmask);
            m_flat = ((m_flat << WIDTH) | s0) & mask;
            m_v    = ((m_v << 1) | int'(EN)) & ((1 << DEPTH) - 1);
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, "_zn"},  32'(ZN),  32'((m_flat >> (WIDTH * (DEPTH - 1))) & ((1 << WIDTH) - 1)));
        chk({tag, "_vld"}, 32'(VLD), 32'((m_v >> (DEPTH - 1)) & 1));
        chk({tag, "_so"},  32'(SO),  32'((m_flat >> (NBITS - 1)) & 1));
    endtask

    task automatic step();
        @(posedge CK);
        model_edge();
        #1;
    endtask

    task automatic set_in(logic en, logic md, logic [WIDTH-1:0] a,
                          logic [WIDTH-1:0] b1, logic [WIDTH-1:0] b2);
        EN = en; MODE = md; A = a; B1 = b1; B2 = b2;
    endtask

    initial begin
        RN = 1'b0; EN = 0; MODE = 0; HOLD = 0; SE = 0; SI = 0;
        A = '0; B1 = '0; B2 = '0;
        #12;
        chk("por_zn", 32'(ZN), 0);
        chk("por_vld", 32'(VLD), 0);
        RN = 1'b1;
        step(); step();
        chk("idle_zn", 32'(ZN), 0);
        chk("idle_vld", 32'(VLD), 0);

        // OAI21 single item
        set_in(1, 0, 4'b1111, 4'b0101, 4'b0011);
        step();
        EN = 0;
        step();
        chk("oai_zn", 32'(ZN), 32'h8);
        chk("oai_vld", 32'(VLD), 1);
        step();
        chk("oai_bubble_vld", 32'(VLD), 0);
        chk("oai_stale_zn", 32'(ZN), 32'h8);

        // AOI21 then OAI21 back-to-back
        set_in(1, 1, 4'b0000, 4'b1100, 4'b1010);
        step();
        set_in(1, 0, 4'b1111, 4'b0000, 4'b0000);
        step();
        chk("b2b0_zn", 32'(ZN), 32'h7);
        chk("b2b0_vld", 32'(VLD), 1);
        EN = 0;
        step();
        chk("b2b1_zn", 32'(ZN), 32'hF);
        chk("b2b1_vld", 32'(VLD), 1);
        step(); step();

        // Hold drops offers and stretches latency
        set_in(1, 0, 4'b1111, 4'b0101, 4'b0011);
        step();
        HOLD = 1;
        set_in(1, 1, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_vld", 32'(VLD), 0);
        end
        HOLD = 0; EN = 0;
        step();
        chk("hold_zn", 32'(ZN), 32'h8);
        chk("hold_vld_out", 32'(VLD), 1);
        step();
        chk("hold_drop_vld", 32'(VLD), 0);
        chk("hold_drop_zn", 32'(ZN), 32'h8);
        step();

        // Scan load of a single one through the full chain
        SE = 1;
        for (int i = 0; i < NBITS; i++) begin
            SI = (i == 0);
            step();
        end
        chk("scan_zn", 32'(ZN), 32'h8);
        chk("scan_so", 32'(SO), 1);
        chk("scan_vld", 32'(VLD), 0);
        SI = 0;
        step();
        chk("scan_out_zn", 32'(ZN), 0);
        chk("scan_out_so", 32'(SO), 0);

        // Async reset mid-shift, then a full reload
        SI = 1;
        step(); step(); step();
        #2 RN = 0;
        m_flat = 0; m_v = 0;
        #1;
        chk("rst_mid_zn", 32'(ZN), 0);
        chk("rst_mid_so", 32'(SO), 0);
        #2 RN = 1;
        for (int i = 0; i < NBITS; i++) begin
            SI = (i == 0);
            step();
            if (i == NBITS - 2) chk("reload_early_so", 32'(SO), 0);
        end
        chk("reload_so", 32'(SO), 1);
        chk("reload_zn", 32'(ZN), 32'h8);
        SE = 0; SI = 0;

        // Async reset with a loaded pipeline, checked before the next edge
        set_in(1, 0, 4'b1111, 4'b0000, 4'b0000);
        step(); step();
        chk_model("pre_rst");
        #3 RN = 0;
        m_flat = 0; m_v = 0;
        #1;
        chk("arst_zn", 32'(ZN), 0);
        chk("arst_vld", 32'(VLD), 0);
        chk("arst_so", 32'(SO), 0);
        #2 RN = 1;
        EN = 0;
        step(); step();
        chk("post_rst_zn", 32'(ZN), 0);
        chk("post_rst_vld", 32'(VLD), 0);

        // Randomized traffic with hold and scan bursts
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
            HOLD = ($urandom_range(0, 3) == 0);
            SE   = ($urandom_range(0, 9) == 0);
            SI   = 1'($urandom_range(0, 1));
            step();
            chk_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
